// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for instr_fetch_unit: PC register link, instruction memory
// req/ack port and the valid/ready handshake toward decode.
// master = fetch unit side, slave = environment side (PC reg, memory, decode).
// Optional macro FETCH_STATS_EN adds the stat_fetched/stat_stall counters.
interface instr_fetch_unit_if;
  logic [31:0] PC;
  logic        PC_WE;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_err;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_stall;
`endif

  modport master (
    input  PC, flush, imem_ack, imem_rdata, instr_ready,
    output PC_WE, imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_err
`ifdef FETCH_STATS_EN
    , output stat_fetched, stat_stall
`endif
  );

  modport slave (
    output PC, flush, imem_ack, imem_rdata, instr_ready,
    input  PC_WE, imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_err
`ifdef FETCH_STATS_EN
    , input stat_fetched, stat_stall
`endif
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage sitting behind the PC register.
// Latches PC, issues one memory read, holds the returned word for decode
// and strobes PC_WE exactly once per delivered instruction. Handles flush
// redirects (outstanding reads are drained, never withdrawn), misaligned
// PCs and memory timeouts; any error parks the unit in ERR until reset.
// Optional macro FETCH_STATS_EN adds saturating fetch/stall counters.
module instr_fetch_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              reset,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    ERR   = 3'd4
  } state_t;

  // Timeout fires when the count of ack-less cycles would reach TIMEOUT_CYCLES.
  localparam logic       TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TMO_LAST = (TIMEOUT_CYCLES != 0) ? 8'(TIMEOUT_CYCLES - 1) : 8'd0;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] addr_r;
  logic [31:0] addr_nxt_s;
  logic [31:0] instr_r;
  logic [31:0] instr_pc_r;
  logic        valid_r;
  logic        err_r;
  logic [7:0]  tmo_cnt_r;

  logic        load_instr_s;
  logic        clr_valid_s;
  logic        busy_s;
  logic        tmo_hit_s;
  logic        tmo_clr_s;
  logic        pc_misaligned_s;

  assign busy_s          = (state_r == REQ) || (state_r == DRAIN);
  assign pc_misaligned_s = (bus.PC[1:0] != 2'b00);
  assign tmo_hit_s       = TMO_EN && (tmo_cnt_r == TMO_LAST);
  // Counter restarts whenever a new REQ or DRAIN phase begins (incl. REQ->DRAIN).
  assign tmo_clr_s       = ((state_nxt_s == REQ) || (state_nxt_s == DRAIN)) &&
                           (state_nxt_s != state_r);

  // Next-state and datapath-control decode for the fetch FSM.
  always_comb begin
    state_nxt_s  = state_r;
    addr_nxt_s   = addr_r;
    load_instr_s = 1'b0;
    clr_valid_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!bus.flush) begin
          addr_nxt_s = bus.PC;
          if (pc_misaligned_s) begin
            state_nxt_s = ERR;
          end else begin
            state_nxt_s = REQ;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (bus.imem_ack) begin
          if (!bus.flush) begin
            load_instr_s = 1'b1;
            state_nxt_s  = HOLD;
          end else begin
            state_nxt_s  = IDLE;
          end
        end else if (tmo_hit_s) begin
          state_nxt_s = ERR;
        end else if (bus.flush) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = REQ;
        end
      end
      DRAIN: begin
        if (bus.imem_ack) begin
          state_nxt_s = IDLE;
        end else if (tmo_hit_s) begin
          state_nxt_s = ERR;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      HOLD: begin
        if (bus.flush) begin
          clr_valid_s = 1'b1;
          state_nxt_s = IDLE;
        end else if (bus.instr_ready) begin
          clr_valid_s = 1'b1;
          addr_nxt_s  = bus.PC;
          if (pc_misaligned_s) begin
            state_nxt_s = ERR;
          end else begin
            state_nxt_s = REQ;
          end
        end else begin
          state_nxt_s = HOLD;
        end
      end
      ERR: begin
        state_nxt_s = ERR;
      end
      default: begin
        clr_valid_s = 1'b1;
        state_nxt_s = ERR;
      end
    endcase
  end

  // FSM state and fetch address registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      addr_r  <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      addr_r  <= addr_nxt_s;
    end
  end

  // Instruction holding register and its valid flag toward decode.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      instr_r    <= 32'd0;
      instr_pc_r <= 32'd0;
      valid_r    <= 1'b0;
    end else if (load_instr_s) begin
      instr_r    <= bus.imem_rdata;
      instr_pc_r <= addr_r;
      valid_r    <= 1'b1;
    end else if (clr_valid_s) begin
      valid_r    <= 1'b0;
    end else begin
      valid_r    <= valid_r;
    end
  end

  // Sticky error flag, raised on the edge that enters ERR.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else if (state_nxt_s == ERR) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Ack-less cycle counter for the memory timeout; saturates at its maximum.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      tmo_cnt_r <= 8'd0;
    end else if (tmo_clr_s) begin
      tmo_cnt_r <= 8'd0;
    end else if (busy_s && !bus.imem_ack && (tmo_cnt_r != 8'hFF)) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  assign bus.imem_req    = busy_s;
  assign bus.imem_addr   = addr_r;
  assign bus.PC_WE       = (state_r == REQ) && bus.imem_ack && !bus.flush;
  assign bus.instr       = instr_r;
  assign bus.instr_pc    = instr_pc_r;
  assign bus.instr_valid = valid_r;
  assign bus.fetch_err   = err_r;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_r;
  logic [31:0] stat_stall_r;

  // Saturating counts of accepted instructions and ack-less REQ cycles.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      stat_fetched_r <= 32'd0;
      stat_stall_r   <= 32'd0;
    end else begin
      if ((state_r == HOLD) && bus.instr_ready && !bus.flush &&
          (stat_fetched_r != 32'hFFFF_FFFF)) begin
        stat_fetched_r <= stat_fetched_r + 32'd1;
      end else begin
        stat_fetched_r <= stat_fetched_r;
      end
      if ((state_r == REQ) && !bus.imem_ack && (stat_stall_r != 32'hFFFF_FFFF)) begin
        stat_stall_r <= stat_stall_r + 32'd1;
      end else begin
        stat_stall_r <= stat_stall_r;
      end
    end
  end

  assign bus.stat_fetched = stat_fetched_r;
  assign bus.stat_stall   = stat_stall_r;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the program-counter register.
- Reads the current PC and issues a req/ack read to instruction memory.
- Holds the returned word for decode behind a valid/ready handshake.
- Pulses PC_WE back to the PC register so the PC advances exactly once per fetched instruction. Handles flush (branch redirect), misaligned PC and memory timeout.

Parameters:
TIMEOUT_CYCLES, 255, max REQ/DRAIN cycles without imem_ack before error; 0 disables timeout; counter width 8 bits (legal range 0-255)

Ports:
CLK  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
PC  input  32  current PC (PC register output)
PC_WE  output  1  advance strobe to PC register WE; combinational
flush  input  1  redirect; upstream loads new target into PC register in same cycle
imem_req  output  1  memory read request
imem_addr  output  32  memory read address
imem_ack  input  1  memory read completion; imem_rdata valid this cycle
imem_rdata  input  32  memory read data
instr  output  32  fetched instruction
instr_pc  output  32  address of instr
instr_valid  output  1  instr/instr_pc valid
instr_ready  input  1  decode accepts when valid && ready
fetch_err  output  1  sticky error flag

Behaviour:
- States: IDLE, REQ, DRAIN, HOLD, ERR. Reset (reset=0, async) -> IDLE.
- Reset values: addr_q=0, instr=0, instr_pc=0, instr_valid=0, fetch_err=0, timeout count=0.
- Output decode:
  - imem_req=1 only in REQ and DRAIN.
  - imem_addr=addr_q in all states.
  - PC_WE = (state==REQ) && imem_ack && !flush.
- IDLE:
  - If flush=0, latch PC into addr_q.
  - If PC[1:0]!=0 -> ERR, no request issued; else -> REQ.
  - If flush=1, stay IDLE.
- REQ:
  - imem_req and imem_addr are held stable until ack.
  - ack && !flush: instr<=imem_rdata, instr_pc<=addr_q, instr_valid<=1, -> HOLD. PC_WE high this cycle, so the PC register updates on the same edge.
  - ack && flush: data discarded, no PC_WE -> IDLE.
  - !ack && flush: -> DRAIN, because a request is never withdrawn.
- DRAIN: imem_req stays high; on ack, data discarded, -> IDLE. No PC_WE.
- HOLD:
  - instr_valid=1; instr/instr_pc stable.
  - flush=1 takes priority over ready: instr_valid<=0, -> IDLE, instruction dropped.
  - instr_ready=1 && flush=0: instr_valid<=0, latch PC, then misaligned -> ERR, else -> REQ.
  - Otherwise remain in HOLD.
- Minimum sequence per instruction is REQ(ack) then HOLD(ready): 2 cycles per instruction with zero-wait memory.
- Timeout:
  - Counter clears on entry to REQ/DRAIN and increments each REQ/DRAIN cycle without ack.
  - Reaching TIMEOUT_CYCLES -> ERR. Applies only if TIMEOUT_CYCLES!=0.
- ERR:
  - fetch_err=1, imem_req=0, instr_valid=0, PC_WE=0.
  - flush is ignored; exit only by reset.
- Reset mid-REQ: request dropped immediately (imem_req=0 asynchronously); memory side must tolerate this.
- No arithmetic on PC; next-PC computation is upstream.

Optional Feature:
FETCH_STATS_EN
- Defined: adds outputs stat_fetched[31:0] and stat_stall[31:0], both reset to 0 and saturating at 32'hFFFFFFFF.
  - stat_fetched increments on each HOLD handshake (valid&&ready&&!flush).
  - stat_stall increments on each REQ cycle with imem_ack=0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, PC=0x00000000, memory acks 1 cycle after req returning 0x20080005, ready=1 -> imem_addr=0x0; instr=0x20080005, instr_pc=0x0; exactly one PC_WE pulse; next req at addr 0x4 once upstream supplies PC=0x4.
- instr_ready=0 for 5 cycles in HOLD -> instr_valid stays 1, instr stable, no new req, no extra PC_WE; ready=1 -> one accept.
- flush asserted with req outstanding at 0x10, ack 3 cycles later, PC loaded 0x40 -> DRAIN, data discarded, no PC_WE, next req addr=0x40.
- flush and instr_ready both high in HOLD -> instruction not accepted, instr_valid=0 next cycle; FETCH_STATS_EN stat_fetched unchanged.
- PC=0x00000006 at latch -> fetch_err=1, imem_req never asserted, flush ignored until reset.
- TIMEOUT_CYCLES=4, no ack -> fetch_err=1 after 4 REQ cycles; reset low mid-ERR clears all outputs to 0.
